// File: rtl/chip8_pkg.sv
// Shared types and constants for the CHIP-8 core: PC update commands,
// fetch FSM states, and fixed memory-map addresses.
package chip8_pkg;

    localparam logic [11:0] RESET_PC_DEFAULT = 12'h200;
    localparam logic [11:0] FONT_BASE        = 12'h000;

    typedef enum logic [2:0] {
        PC_NEXT = 3'd0,
        PC_SKIP = 3'd1,
        PC_JUMP = 3'd2,
        PC_CALL = 3'd3,
        PC_RET  = 3'd4
    } pc_cmd_e;

    typedef enum logic [1:0] {
        RD_HI = 2'd0,
        RD_LO = 2'd1,
        LATCH = 2'd2,
        VALID = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/chip8_fetch_if.sv
// Memory read port plus the opcode/PC-command handshake between fetch and execute.
interface chip8_fetch_if;
    logic [11:0] mem_addr;
    logic [7:0]  mem_dout;
    logic        op_valid;
    logic        op_ready;
    logic [15:0] op;
    logic [11:0] op_pc;
    logic [2:0]  pc_cmd;
    logic [11:0] pc_target;
    logic        stack_err;

    modport master (
        output mem_addr, op_valid, op, op_pc, stack_err,
        input  mem_dout, op_ready, pc_cmd, pc_target
    );

    modport slave (
        input  mem_addr, op_valid, op, op_pc, stack_err,
        output mem_dout, op_ready, pc_cmd, pc_target
    );
endinterface

// File: rtl/chip8_call_stack.sv
// Return-address stack: STACK_DEPTH x 12-bit entries, pointer holds 0..STACK_DEPTH.
module chip8_call_stack #(
    parameter int STACK_DEPTH = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        i_push,
    input  logic        i_pop,
    input  logic [11:0] i_data,
    output logic [11:0] o_top,
    output logic        o_full,
    output logic        o_empty
);
    localparam int IW = $clog2(STACK_DEPTH);
    localparam int PW = IW + 1;

    logic [PW-1:0] r_sp;
    logic [11:0]   r_mem [STACK_DEPTH];
    logic [PW-1:0] w_sp_m1;
    logic          w_do_push;
    logic          w_do_pop;

    assign o_full    = (r_sp == PW'(STACK_DEPTH));
    assign o_empty   = (r_sp == '0);
    assign w_sp_m1   = r_sp - PW'(1);
    assign o_top     = r_mem[w_sp_m1[IW-1:0]];
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sp <= '0;
        end else if (w_do_push) begin
            r_sp <= r_sp + PW'(1);
        end else if (w_do_pop) begin
            r_sp <= w_sp_m1;
        end
    end

    // Entries are deliberately left unreset; only the pointer defines validity.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_sp[IW-1:0]] <= i_data;
        end
    end
endmodule

// File: rtl/chip8_fetch.sv
// CHIP-8 fetch stage: owns PC and call stack, reads two bytes per opcode from a
// 1-cycle-latency memory and hands a big-endian opcode to execute.
module chip8_fetch
    import chip8_pkg::*;
#(
    parameter logic [11:0] RESET_PC    = RESET_PC_DEFAULT,
    parameter int          STACK_DEPTH = 16
) (
    input  logic          clk,
    input  logic          reset_n,
    chip8_fetch_if.master bus
);
    fetch_state_e r_state;
    fetch_state_e w_next_state;

    logic [11:0] r_pc;
    logic [15:0] r_op;
    logic [11:0] r_op_pc;
    logic        r_stack_err;

    logic [11:0] w_pc_inc1;
    logic [11:0] w_pc_inc2;
    logic [11:0] w_pc_next;
    logic        w_accept;
    logic        w_push;
    logic        w_pop;
    logic        w_err_set;
    logic [11:0] w_top;
    logic        w_full;
    logic        w_empty;
    logic [11:0] w_mem_addr;
    logic        w_op_valid;

    assign w_pc_inc1 = r_pc + 12'd1;
    assign w_pc_inc2 = r_pc + 12'd2;
    assign w_accept  = (r_state == VALID) && bus.op_ready;

    chip8_call_stack #(.STACK_DEPTH(STACK_DEPTH)) u_stack (
        .clk     (clk),
        .reset_n (reset_n),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_data  (w_pc_inc2),
        .o_top   (w_top),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= RD_HI;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            RD_HI:   w_next_state = RD_LO;
            RD_LO:   w_next_state = LATCH;
            LATCH:   w_next_state = VALID;
            VALID:   w_next_state = w_accept ? RD_HI : VALID;
            default: w_next_state = RD_HI;
        endcase
    end

    always_comb begin
        w_mem_addr = r_pc;
        w_op_valid = 1'b0;
        case (r_state)
            RD_LO:   w_mem_addr = w_pc_inc1;
            VALID:   w_op_valid = 1'b1;
            default: w_mem_addr = r_pc;
        endcase
    end

    // PC command decode; unknown encodings behave as NEXT.
    always_comb begin
        w_pc_next = w_pc_inc2;
        w_push    = 1'b0;
        w_pop     = 1'b0;
        w_err_set = 1'b0;
        if (w_accept) begin
            case (bus.pc_cmd)
                PC_SKIP: w_pc_next = r_pc + 12'd4;
                PC_JUMP: w_pc_next = bus.pc_target;
                PC_CALL: begin
                    if (!w_full) begin
                        w_push    = 1'b1;
                        w_pc_next = bus.pc_target;
                    end else begin
                        w_err_set = 1'b1;
                    end
                end
                PC_RET: begin
                    if (!w_empty) begin
                        w_pop     = 1'b1;
                        w_pc_next = w_top;
                    end else begin
                        w_err_set = 1'b1;
                    end
                end
                default: w_pc_next = w_pc_inc2;
            endcase
        end
    end

    // Memory data lags the address by one cycle: the high byte is on mem_dout
    // during RD_LO and the low byte during LATCH.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pc        <= RESET_PC;
            r_op        <= 16'h0000;
            r_op_pc     <= 12'h000;
            r_stack_err <= 1'b0;
        end else begin
            if (r_state == RD_LO) begin
                r_op[15:8] <= bus.mem_dout;
            end
            if (r_state == LATCH) begin
                r_op[7:0] <= bus.mem_dout;
                r_op_pc   <= r_pc;
            end
            if (w_accept) begin
                r_pc <= w_pc_next;
            end
            if (w_err_set) begin
                r_stack_err <= 1'b1;
            end
        end
    end

    assign bus.mem_addr  = w_mem_addr;
    assign bus.op_valid  = w_op_valid;
    assign bus.op        = r_op;
    assign bus.op_pc     = r_op_pc;
    assign bus.stack_err = r_stack_err;
endmodule

// File: tb/tb_chip8_fetch.sv
// Bench for chip8_fetch: behavioural memory, PC/stack model feeding an
// expected-opcode queue that is popped each time the DUT presents an opcode.
module tb_chip8_fetch;
    import chip8_pkg::*;

    typedef struct packed {
        logic [15:0] op;
        logic [11:0] pc;
    } exp_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    chip8_fetch_if bus();

    chip8_fetch #(.RESET_PC(12'h200), .STACK_DEPTH(16)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    logic [7:0]  mem [4096];
    always @(posedge clk) bus.mem_dout <= mem[bus.mem_addr];

    exp_t        sb[$];
    int          checks = 0;
    int          fails = 0;
    logic [11:0] pc_m;
    logic [11:0] stk_m [16];
    int          sp_m;
    logic        err_m;
    logic [11:0] addr_seq [3];

    function automatic exp_t mk_exp(input logic [11:0] a);
        logic [11:0] b;
        b = a + 12'd1;
        return {mem[a], mem[b], a};
    endfunction

    task automatic model_reset();
        pc_m  = 12'h200;
        sp_m  = 0;
        err_m = 1'b0;
        sb.delete();
        sb.push_back(mk_exp(pc_m));
    endtask

    task automatic next_op(output bit ok, output exp_t e);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.op_valid === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        e = (sb.size() > 0) ? sb.pop_front() : '0;
    endtask

    // Called at a negedge with op_valid high; returns at the negedge after accept.
    task automatic drive_accept(input logic [2:0] cmd, input logic [11:0] tgt);
        bus.op_ready  = 1'b1;
        bus.pc_cmd    = cmd;
        bus.pc_target = tgt;
        @(posedge clk);
        case (cmd)
            PC_SKIP: pc_m = pc_m + 12'd4;
            PC_JUMP: pc_m = tgt;
            PC_CALL: begin
                if (sp_m < 16) begin
                    stk_m[sp_m] = pc_m + 12'd2;
                    sp_m++;
                    pc_m = tgt;
                end else begin
                    err_m = 1'b1;
                    pc_m  = pc_m + 12'd2;
                end
            end
            PC_RET: begin
                if (sp_m > 0) begin
                    sp_m--;
                    pc_m = stk_m[sp_m];
                end else begin
                    err_m = 1'b1;
                    pc_m  = pc_m + 12'd2;
                end
            end
            default: pc_m = pc_m + 12'd2;
        endcase
        sb.push_back(mk_exp(pc_m));
        @(negedge clk);
        bus.op_ready  = 1'b0;
        bus.pc_cmd    = 3'($urandom);
        bus.pc_target = 12'($urandom);
    endtask

    task automatic test_reset();
        bus.op_ready  = 1'b0;
        bus.pc_cmd    = 3'd0;
        bus.pc_target = 12'h000;
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (bus.op_valid !== 1'b0 || bus.op !== 16'h0000 || bus.op_pc !== 12'h000 || bus.stack_err !== 1'b0) begin
            fails++;
            $display("FAIL reset_vals: valid=%b op=%h op_pc=%h err=%b expected 0/0000/000/0",
                     bus.op_valid, bus.op, bus.op_pc, bus.stack_err);
        end
        model_reset();
        reset_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (bus.mem_addr !== addr_seq[k] || bus.op_valid !== 1'b0) begin
                fails++;
                $display("FAIL reset_addr_seq[%0d]: addr=%h valid=%b expected addr=%h valid=0",
                         k, bus.mem_addr, bus.op_valid, addr_seq[k]);
            end
            @(negedge clk);
        end
        begin
            exp_t e;
            e = sb.pop_front();
            checks++;
            if (bus.op_valid !== 1'b1 || bus.op !== e.op || bus.op_pc !== e.pc || bus.op !== 16'h1234) begin
                fails++;
                $display("FAIL first_op: valid=%b op=%h op_pc=%h expected valid=1 op=%h op_pc=%h",
                         bus.op_valid, bus.op, bus.op_pc, e.op, e.pc);
            end
        end
    endtask

    task automatic test_jump_skip();
        bit ok;
        exp_t e;
        drive_accept(PC_JUMP, 12'h000);
        checks++;
        if (bus.op_valid !== 1'b0) begin
            fails++;
            $display("FAIL valid_drop: valid=%b expected 0", bus.op_valid);
        end
        next_op(ok, e);
        checks++;
        if (!ok || bus.op !== e.op || bus.op_pc !== e.pc || bus.op !== 16'hF090) begin
            fails++;
            $display("FAIL jump_font: ok=%b op=%h op_pc=%h expected op=%h op_pc=%h", ok, bus.op, bus.op_pc, e.op, e.pc);
        end
        drive_accept(PC_SKIP, 12'h000);
        next_op(ok, e);
        checks++;
        if (!ok || bus.op !== e.op || bus.op_pc !== 12'h004 || bus.op !== 16'hF020) begin
            fails++;
            $display("FAIL skip: ok=%b op=%h op_pc=%h expected op=%h op_pc=%h", ok, bus.op, bus.op_pc, e.op, e.pc);
        end
    endtask

    task automatic test_backpressure();
        bit ok;
        bit stable;
        exp_t e;
        logic [15:0] op0;
        logic [11:0] pc0;
        op0 = bus.op;
        pc0 = bus.op_pc;
        bus.pc_cmd    = PC_JUMP;
        bus.pc_target = 12'h123;
        stable = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (bus.op_valid !== 1'b1 || bus.op !== op0 || bus.op_pc !== pc0) stable = 1'b0;
        end
        checks++;
        if (!stable) begin
            fails++;
            $display("FAIL backpressure_hold: valid=%b op=%h op_pc=%h expected 1/%h/%h", bus.op_valid, bus.op, bus.op_pc, op0, pc0);
        end
        drive_accept(PC_JUMP, 12'hFFE);
        next_op(ok, e);
        checks++;
        if (!ok || bus.op !== e.op || bus.op_pc !== 12'hFFE) begin
            fails++;
            $display("FAIL jump_ffe: ok=%b op=%h op_pc=%h expected op=%h op_pc=%h", ok, bus.op, bus.op_pc, e.op, e.pc);
        end
        drive_accept(PC_NEXT, 12'h000);
        next_op(ok, e);
        checks++;
        if (!ok || bus.op !== e.op || bus.op_pc !== 12'h000) begin
            fails++;
            $display("FAIL next_wrap: ok=%b op=%h op_pc=%h expected op=%h op_pc=000", ok, bus.op, bus.op_pc, e.op);
        end
    endtask

    task automatic test_unaligned();
        bit ok;
        exp_t e;
        logic [11:0] seq [3];
        seq[0] = 12'hFFF; seq[1] = 12'h000; seq[2] = 12'hFFF;
        drive_accept(PC_JUMP, 12'hFFF);
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (bus.mem_addr !== seq[k]) begin
                fails++;
                $display("FAIL unaligned_addr[%0d]: addr=%h expected %h", k, bus.mem_addr, seq[k]);
            end
            if (k < 2) @(negedge clk);
        end
        next_op(ok, e);
        checks++;
        if (!ok || bus.op !== e.op || bus.op_pc !== 12'hFFF || bus.op !== {mem[12'hFFF], mem[12'h000]}) begin
            fails++;
            $display("FAIL unaligned_op: ok=%b op=%h op_pc=%h expected op=%h op_pc=FFF", ok, bus.op, bus.op_pc, e.op);
        end
    endtask

    task automatic test_call_ret();
        bit ok;
        exp_t e;
        drive_accept(PC_JUMP, 12'h200);
        next_op(ok, e);
        drive_accept(PC_CALL, 12'h300);
        next_op(ok, e);
        checks++;
        if (!ok || bus.op !== e.op || bus.op_pc !== 12'h300) begin
            fails++;
            $display("FAIL call: ok=%b op=%h op_pc=%h expected op=%h op_pc=300", ok, bus.op, bus.op_pc, e.op);
        end
        drive_accept(PC_RET, 12'h000);
        next_op(ok, e);
        checks++;
        if (!ok || bus.op !== e.op || bus.op_pc !== 12'h202 || bus.stack_err !== 1'b0) begin
            fails++;
            $display("FAIL ret: ok=%b op=%h op_pc=%h err=%b expected op=%h op_pc=202 err=0",
                     ok, bus.op, bus.op_pc, bus.stack_err, e.op);
        end
        for (int i = 0; i < 17; i++) begin
            drive_accept(PC_CALL, 12'h400 + 12'(i * 16));
            next_op(ok, e);
            checks++;
            if (!ok || bus.op !== e.op || bus.op_pc !== e.pc || bus.stack_err !== err_m) begin
                fails++;
                $display("FAIL nested_call[%0d]: ok=%b op=%h op_pc=%h err=%b expected op=%h op_pc=%h err=%b",
                         i, ok, bus.op, bus.op_pc, bus.stack_err, e.op, e.pc, err_m);
            end
        end
        checks++;
        if (bus.stack_err !== 1'b1 || bus.op_pc !== 12'h4F2) begin
            fails++;
            $display("FAIL overflow: err=%b op_pc=%h expected err=1 op_pc=4F2", bus.stack_err, bus.op_pc);
        end
    endtask

    task automatic test_ret_empty();
        bit ok;
        exp_t e;
        reset_n = 1'b0;
        @(negedge clk);
        model_reset();
        reset_n = 1'b1;
        next_op(ok, e);
        checks++;
        if (!ok || bus.op !== e.op || bus.op_pc !== 12'h200 || bus.stack_err !== 1'b0) begin
            fails++;
            $display("FAIL rst_refetch: ok=%b op=%h op_pc=%h err=%b expected op=%h op_pc=200 err=0",
                     ok, bus.op, bus.op_pc, bus.stack_err, e.op);
        end
        drive_accept(PC_RET, 12'h000);
        next_op(ok, e);
        checks++;
        if (!ok || bus.op !== e.op || bus.op_pc !== 12'h202 || bus.stack_err !== 1'b1) begin
            fails++;
            $display("FAIL ret_empty: ok=%b op=%h op_pc=%h err=%b expected op=%h op_pc=202 err=1",
                     ok, bus.op, bus.op_pc, bus.stack_err, e.op);
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        exp_t e;
        drive_accept(PC_NEXT, 12'h000);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        checks++;
        if (bus.op_valid !== 1'b0 || bus.stack_err !== 1'b0 || bus.op_pc !== 12'h000 || bus.mem_addr !== 12'h200) begin
            fails++;
            $display("FAIL reset_mid: valid=%b err=%b op_pc=%h addr=%h expected 0/0/000/200",
                     bus.op_valid, bus.stack_err, bus.op_pc, bus.mem_addr);
        end
        @(negedge clk);
        model_reset();
        reset_n = 1'b1;
        next_op(ok, e);
        checks++;
        if (!ok || bus.op !== e.op || bus.op_pc !== 12'h200) begin
            fails++;
            $display("FAIL reset_mid_restart: ok=%b op=%h op_pc=%h expected op=%h op_pc=200", ok, bus.op, bus.op_pc, e.op);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = 8'(i * 7 + 3) ^ 8'(i >> 8);
        mem[0] = 8'hF0; mem[1] = 8'h90; mem[2] = 8'h90; mem[3] = 8'h90; mem[4] = 8'hF0;
        mem[5] = 8'h20; mem[6] = 8'h60; mem[7] = 8'h20; mem[8] = 8'h20; mem[9] = 8'h70;
        mem[12'h200] = 8'h12;
        mem[12'h201] = 8'h34;
        addr_seq[0] = 12'h200; addr_seq[1] = 12'h201; addr_seq[2] = 12'h200;

        test_reset();
        test_jump_skip();
        test_backpressure();
        test_unaligned();
        test_call_ret();
        test_ret_empty();
        test_reset_mid();

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
